// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RISC-V immediate generator with output FIFO; IMMGEN_ZIMM_EN enables the Z (CSR uimm) format
module imm_gen_pipe #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 2,
    parameter int TAG_W    = 5,
    parameter int AUTO_SEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_sel,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_RSV  = 3'd7
    } fmt_e;

    fmt_e              w_fmt;
    logic [31:0]       w_imm32;
    logic              w_sext;
    logic [XLEN-1:0]   w_imm;
    logic              w_full;
    logic              w_push;
    logic              w_pop;

    logic [XLEN-1:0]   r_imm [DEPTH];
    logic [2:0]        r_sel [DEPTH];
    logic [TAG_W-1:0]  r_tag [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    always_comb begin
        w_fmt = FMT_NONE;
        if (AUTO_SEL != 0) begin
            case (in_inst[6:0])
                7'b0010011, 7'b0000011, 7'b1100111: w_fmt = FMT_I;
                7'b1110011: begin
`ifdef IMMGEN_ZIMM_EN
                    w_fmt = in_inst[14] ? FMT_Z : FMT_I;
`else
                    w_fmt = FMT_I;
`endif
                end
                7'b0100011:             w_fmt = FMT_S;
                7'b1100011:             w_fmt = FMT_B;
                7'b0110111, 7'b0010111: w_fmt = FMT_U;
                7'b1101111:             w_fmt = FMT_J;
                default:                w_fmt = FMT_NONE;
            endcase
        end else begin
            case (in_sel)
                3'd1, 3'd2, 3'd3, 3'd4, 3'd5: w_fmt = fmt_e'(in_sel);
`ifdef IMMGEN_ZIMM_EN
                3'd6:    w_fmt = FMT_Z;
`endif
                default: w_fmt = FMT_NONE;
            endcase
        end
    end

    // w_imm32 already holds a 32-bit sign extension; w_sext widens it further for XLEN=64
    always_comb begin
        w_imm32 = 32'd0;
        w_sext  = 1'b1;
        case (w_fmt)
            FMT_I: w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            FMT_S: w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            FMT_B: w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                              in_inst[30:25], in_inst[11:8], 1'b0};
            FMT_U: w_imm32 = {in_inst[31:12], 12'd0};
            FMT_J: w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                              in_inst[20], in_inst[30:21], 1'b0};
            FMT_Z: begin
                w_imm32 = {27'd0, in_inst[19:15]};
                w_sext  = 1'b0;
            end
            default: w_sext = 1'b0;
        endcase
        w_imm = w_sext ? XLEN'($signed(w_imm32)) : XLEN'(w_imm32);
    end

    assign w_full    = (r_count == CW'(DEPTH));
    assign in_ready  = !w_full;
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && !w_full;
    assign w_pop     = out_valid && out_ready;

    assign out_imm = r_imm[r_rd_ptr];
    assign out_sel = r_sel[r_rd_ptr];
    assign out_tag = r_tag[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_imm[i] <= '0;
                r_sel[i] <= '0;
                r_tag[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_imm[r_wr_ptr] <= w_imm;
                r_sel[r_wr_ptr] <= w_fmt;
                r_tag[r_wr_ptr] <= in_tag;
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe (XLEN=32/DEPTH=2 auto, XLEN=64/DEPTH=3 select)
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  sel;
        logic [4:0]  tag;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_inst;
    logic [2:0]  a_in_sel, a_out_sel;
    logic [4:0]  a_in_tag, a_out_tag;
    logic [31:0] a_out_imm;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_inst;
    logic [2:0]  b_in_sel, b_out_sel;
    logic [4:0]  b_in_tag, b_out_tag;
    logic [63:0] b_out_imm;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;
    bit   acc_a, acc_b;
    ent_t qa[$];
    ent_t qb[$];
    logic [4:0] a_log[$];
    logic [4:0] b_log[$];
    logic [31:0] wrap_inst [4] = '{32'hFFF00093, 32'hFE000EE3, 32'h123450B7, 32'h00A00013};

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(5), .AUTO_SEL(1)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inst(a_in_inst),
        .in_sel(a_in_sel), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
        .out_sel(a_out_sel), .out_tag(a_out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(3), .TAG_W(5), .AUTO_SEL(0)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst),
        .in_sel(b_in_sel), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
        .out_sel(b_out_sel), .out_tag(b_out_tag)
    );

    // Reference: field value as a signed integer, widened to 64 bits by ordinary arithmetic
    function automatic ent_t model_entry(input logic [31:0] inst, input logic [2:0] sel,
                                         input bit auto_sel, input logic [4:0] tag);
        ent_t        e;
        int          fmt;
        bit          zen;
        longint      v;
        logic [11:0] f12;
        logic [12:0] f13;
        logic [20:0] f21;
        logic [31:0] u;
`ifdef IMMGEN_ZIMM_EN
        zen = 1'b1;
`else
        zen = 1'b0;
`endif
        if (auto_sel) begin
            case (inst[6:0])
                7'h13, 7'h03, 7'h67: fmt = 1;
                7'h73:               fmt = (zen && inst[14]) ? 6 : 1;
                7'h23:               fmt = 2;
                7'h63:               fmt = 3;
                7'h37, 7'h17:        fmt = 4;
                7'h6F:               fmt = 5;
                default:             fmt = 0;
            endcase
        end else begin
            fmt = int'(sel);
            if (fmt == 7 || (fmt == 6 && !zen)) fmt = 0;
        end
        v = 0;
        case (fmt)
            1: begin f12 = inst[31:20]; v = longint'($signed(f12)); end
            2: begin f12 = {inst[31:25], inst[11:7]}; v = longint'($signed(f12)); end
            3: begin
                f13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                v = longint'($signed(f13));
            end
            4: begin u = {inst[31:12], 12'h000}; v = longint'($signed(u)); end
            5: begin
                f21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                v = longint'($signed(f21));
            end
            6: v = longint'(inst[19:15]);
            default: v = 0;
        endcase
        e.imm = v;
        e.sel = fmt[2:0];
        e.tag = tag;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst || flush) begin
            qa.delete();
            qb.delete();
        end else begin
            acc_a = a_in_valid && (qa.size() < 2);
            acc_b = b_in_valid && (qb.size() < 3);
            if (a_out_ready && qa.size() > 0) begin
                a_log.push_back(qa[0].tag);
                void'(qa.pop_front());
            end
            if (b_out_ready && qb.size() > 0) begin
                b_log.push_back(qb[0].tag);
                void'(qb.pop_front());
            end
            if (acc_a) qa.push_back(model_entry(a_in_inst, a_in_sel, 1'b1, a_in_tag));
            if (acc_b) qb.push_back(model_entry(b_in_inst, b_in_sel, 1'b0, b_in_tag));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_out_valid", a_out_valid, qa.size() != 0);
            chk("a_in_ready", a_in_ready, qa.size() < 2);
            if (qa.size() != 0) begin
                chk("a_out_imm", a_out_imm, qa[0].imm[31:0]);
                chk("a_out_sel", a_out_sel, qa[0].sel);
                chk("a_out_tag", a_out_tag, qa[0].tag);
            end
            chk("b_out_valid", b_out_valid, qb.size() != 0);
            chk("b_in_ready", b_in_ready, qb.size() < 3);
            if (qb.size() != 0) begin
                chk("b_out_imm", b_out_imm, qb[0].imm);
                chk("b_out_sel", b_out_sel, qb[0].sel);
                chk("b_out_tag", b_out_tag, qb[0].tag);
            end
        end
    end

    // Holds the request until an edge where the DUT was ready; returns just after that edge
    task automatic push(input bit which, input logic [31:0] inst, input logic [2:0] sel,
                        input logic [4:0] tag);
        int n = 0;
        if (which) begin
            b_in_valid = 1'b1; b_in_inst = inst; b_in_sel = sel; b_in_tag = tag;
        end else begin
            a_in_valid = 1'b1; a_in_inst = inst; a_in_sel = sel; a_in_tag = tag;
        end
        while (!(which ? b_in_ready : a_in_ready) && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: got in_ready=0 for 50 cycles, expected 1 (tag %0d)", tag);
        end else begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic vec(input bit which, input logic [31:0] inst, input logic [2:0] sel,
                       input logic [4:0] tag, input logic [63:0] exp_imm,
                       input logic [2:0] exp_sel, input string name);
        push(which, inst, sel, tag);
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        @(negedge clk);
        if (which) begin
            chk({name, "_imm"}, b_out_imm, exp_imm);
            chk({name, "_sel"}, b_out_sel, exp_sel);
        end else begin
            chk({name, "_imm"}, {32'd0, a_out_imm}, exp_imm);
            chk({name, "_sel"}, a_out_sel, exp_sel);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        a_in_valid = 1'b0; a_in_inst = '0; a_in_sel = '0; a_in_tag = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_inst = '0; b_in_sel = '0; b_in_tag = '0; b_out_ready = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_a_valid", a_out_valid, 1'b0);
        chk("rst_a_ready", a_in_ready, 1'b1);
        chk("rst_a_imm", a_out_imm, 32'd0);
        chk("rst_a_sel", a_out_sel, 3'd0);
        chk("rst_a_tag", a_out_tag, 5'd0);
        chk("rst_b_imm", b_out_imm, 64'd0);
        chk("rst_b_valid", b_out_valid, 1'b0);
        chk_en = 1'b1;

        vec(0, 32'hFFF00093, 3'd0, 5'd1, 64'h00000000FFFFFFFF, 3'd1, "i_type");
        vec(0, 32'hFE000EE3, 3'd0, 5'd2, 64'h00000000FFFFFFFC, 3'd3, "b_type");
        vec(0, 32'h123450B7, 3'd0, 5'd3, 64'h0000000012345000, 3'd4, "u_type");
        vec(0, 32'hFE112E23, 3'd0, 5'd4, 64'h00000000FFFFFFFC, 3'd2, "s_type");
        vec(0, 32'h00208033, 3'd0, 5'd5, 64'h0000000000000000, 3'd0, "none_op");
`ifdef IMMGEN_ZIMM_EN
        vec(0, 32'h300FD073, 3'd0, 5'd6, 64'h000000000000001F, 3'd6, "csr_auto");
        vec(1, 32'h300FD073, 3'd6, 5'd7, 64'h000000000000001F, 3'd6, "csr_sel6");
`else
        vec(0, 32'h300FD073, 3'd0, 5'd6, 64'h0000000000000300, 3'd1, "csr_auto");
        vec(1, 32'h300FD073, 3'd6, 5'd7, 64'h0000000000000000, 3'd0, "csr_sel6");
`endif
        vec(1, 32'h800000B7, 3'd4, 5'd8, 64'hFFFFFFFF80000000, 3'd4, "u64");
        vec(1, 32'hFFF00093, 3'd7, 5'd9, 64'h0000000000000000, 3'd0, "sel7");
        vec(1, 32'h8000006F, 3'd5, 5'd10, 64'hFFFFFFFFFFF00000, 3'd5, "j64");
        idle(2);

        // Back-pressure on the DEPTH=2 instance
        a_log.delete();
        a_out_ready = 1'b0;
        push(0, 32'h00100093, 3'd0, 5'd0);
        push(0, 32'h00200093, 3'd0, 5'd1);
        a_in_valid = 1'b1; a_in_inst = 32'h00300093; a_in_tag = 5'd2;
        repeat (2) @(negedge clk);
        chk("bp_in_ready", a_in_ready, 1'b0);
        chk("bp_head_tag", a_out_tag, 5'd0);
        chk("bp_head_imm", a_out_imm, 32'd1);
        @(posedge clk);
        #2;
        a_out_ready = 1'b1;
        push(0, 32'h00300093, 3'd0, 5'd2);
        a_in_valid = 1'b0;
        idle(4);
        chk("bp_log_n", a_log.size(), 3);
        for (int i = 0; i < 3 && i < a_log.size(); i++) chk("bp_log_tag", a_log[i], i);

        // Wrap-around on the DEPTH=3 instance with toggling back-pressure
        b_log.delete();
        fork
            begin
                for (int i = 0; i < 10; i++)
                    push(1, wrap_inst[i % 4], 3'((i % 5) + 1), 5'(i));
                b_in_valid = 1'b0;
            end
            begin
                repeat (40) begin
                    @(posedge clk);
                    #2;
                    b_out_ready = !b_out_ready;
                end
            end
        join
        b_out_ready = 1'b1;
        idle(6);
        chk("wrap_log_n", b_log.size(), 10);
        for (int i = 0; i < 10 && i < b_log.size(); i++) chk("wrap_log_tag", b_log[i], i);

        // Flush with a full FIFO and a pending input in the same cycle
        a_out_ready = 1'b0;
        push(0, 32'h00500093, 3'd0, 5'd3);
        push(0, 32'h00600093, 3'd0, 5'd4);
        a_in_valid = 1'b1; a_in_inst = 32'h00700093; a_in_tag = 5'd31;
        flush = 1'b1;
        @(posedge clk);
        #2;
        flush = 1'b0;
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", a_out_valid, 1'b0);
        chk("flush_ready", a_in_ready, 1'b1);
        a_log.delete();
        a_out_ready = 1'b1;
        idle(4);
        chk("flush_nothing_out", a_log.size(), 0);

        // Reset in the middle of traffic
        b_out_ready = 1'b0;
        push(1, 32'h00800093, 3'd1, 5'd7);
        push(1, 32'h00900093, 3'd1, 5'd8);
        b_in_valid = 1'b1; b_in_tag = 5'd9;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", b_out_valid, 1'b0);
        chk("mid_rst_ready", b_in_ready, 1'b1);
        b_out_ready = 1'b1;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000 time units, expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

endmodule
